// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way arbiter with registered one-hot grant, fixed-priority or
// round-robin selection, and grant hold bounded by MAX_HOLD while others wait.
module rr_arbiter #(
    parameter int N        = 16,
    parameter int MAX_HOLD = 4,
    parameter int IDXW     = $clog2(N)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            en,
    input  logic            rr_mode,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [IDXW-1:0] gnt_idx,
    output logic            req_up
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] LAST = HW'(MAX_HOLD - 1);

    logic            busy;
    logic [IDXW-1:0] owner, ptr, fix_w, rr_w, win;
    logic [HW-1:0]   hold_cnt;
    logic [N-1:0]    own_mask, cand;
    logic            others, keep;

    assign req_up   = |req;
    assign own_mask = {{(N-1){1'b0}}, 1'b1} << owner;
    assign others   = |(req & ~own_mask);
    assign keep     = busy && req[owner] && (hold_cnt < LAST || !others);
    // Reaching here with the owner still requesting means tenure expired.
    assign cand     = (busy && req[owner]) ? (req & ~own_mask) : req;
    assign win      = rr_mode ? rr_w : fix_w;

    always_comb begin
        fix_w = '0;
        for (int i = 0; i < N; i++)
            if (cand[i]) fix_w = IDXW'(i);
    end

    // Scan offsets from far to near so the nearest index after ptr wins.
    always_comb begin
        rr_w = '0;
        for (int k = N - 1; k >= 0; k--)
            if (cand[(int'(ptr) + 1 + k) % N]) rr_w = IDXW'((int'(ptr) + 1 + k) % N);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            owner     <= '0;
            ptr       <= IDXW'(N - 1);
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
        end else if (!en || (!keep && !(|cand))) begin
            busy      <= 1'b0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
        end else if (keep) begin
            hold_cnt <= (hold_cnt == LAST) ? '0 : hold_cnt + 1'b1;
        end else begin
            busy      <= 1'b1;
            owner     <= win;
            ptr       <= win;
            hold_cnt  <= '0;
            gnt       <= {{(N-1){1'b0}}, 1'b1} << win;
            gnt_valid <= 1'b1;
            gnt_idx   <= win;
        end
    end
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: scoreboard bench for rr_arbiter with N=4 at MAX_HOLD=4 and MAX_HOLD=1.
module tb_rr_arbiter;
    logic       clock = 1'b0, reset = 1'b1, en = 1'b1, rr_mode = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] gnt, gnt1;
    logic       gv, gv1, ru, ru1;
    logic [1:0] gi, gi1;

    typedef struct {
        logic [3:0] g0;
        logic [3:0] g1;
        bit         c1;
        string      nm;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   checks = 0, errors = 0;

    rr_arbiter #(.N(4), .MAX_HOLD(4)) dut (
        .clock(clock), .reset(reset), .en(en), .rr_mode(rr_mode), .req(req),
        .gnt(gnt), .gnt_valid(gv), .gnt_idx(gi), .req_up(ru)
    );

    rr_arbiter #(.N(4), .MAX_HOLD(1)) dut1 (
        .clock(clock), .reset(reset), .en(en), .rr_mode(rr_mode), .req(req),
        .gnt(gnt1), .gnt_valid(gv1), .gnt_idx(gi1), .req_up(ru1)
    );

    always #5 clock = ~clock;

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [3:0] g, input logic v,
                       input logic [1:0] i, input logic [3:0] eg);
        checks++;
        if (g !== eg || v !== (|eg) || i !== idx_of(eg)) begin
            errors++;
            $display("FAIL %s: gnt=%b valid=%b idx=%0d, expected gnt=%b valid=%b idx=%0d",
                     nm, g, v, i, eg, |eg, idx_of(eg));
        end
    endtask

    task automatic cyc(input logic [3:0] r, input logic e, input logic m,
                       input logic [3:0] x0, input logic [3:0] x1, input bit c1,
                       input string nm);
        req = r;
        en = e;
        rr_mode = m;
        q.push_back('{x0, x1, c1, nm});
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req = '0;
        en = 1'b1;
        #2;
        chk("reset_h4", gnt, gv, gi, 4'b0000);
        chk("reset_h1", gnt1, gv1, gi1, 4'b0000);
        @(negedge clock);
        reset = 1'b0;
    endtask

    always @(posedge clock) begin
        #1;
        if (q.size() != 0) begin
            cur = q.pop_front();
            chk(cur.nm, gnt, gv, gi, cur.g0);
            if (cur.c1) chk({cur.nm, "_h1"}, gnt1, gv1, gi1, cur.g1);
            checks++;
            if (ru !== (|req) || ru1 !== (|req)) begin
                errors++;
                $display("FAIL req_up: got %b/%b, expected %b", ru, ru1, |req);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        for (int i = 0; i < 4; i++) cyc(4'b0101, 1, 0, 4'b0100, 4'b0000, 0, "fix_hi");
        for (int i = 0; i < 4; i++) cyc(4'b0101, 1, 0, 4'b0001, 4'b0000, 0, "fix_lo");
        for (int i = 0; i < 2; i++) cyc(4'b0101, 1, 0, 4'b0100, 4'b0000, 0, "fix_back");

        do_reset();
        for (int i = 0; i < 8; i++)
            cyc(4'b1111, 1, 1, (i < 4) ? 4'b0001 : 4'b0010, 4'b0001 << (i % 4), 1, "rr_all");

        do_reset();
        for (int i = 0; i < 10; i++) cyc(4'b0100, 1, 1, 4'b0100, 4'b0100, 1, "solo_hold");
        cyc(4'b0000, 1, 1, 4'b0000, 4'b0000, 1, "solo_drop");

        do_reset();
        cyc(4'b0010, 1, 1, 4'b0010, 4'b0010, 1, "own1");
        cyc(4'b1010, 1, 1, 4'b0010, 4'b1000, 1, "own1_wait3");
        cyc(4'b1000, 1, 1, 4'b1000, 4'b1000, 1, "release_to3");

        do_reset();
        cyc(4'b0011, 1, 1, 4'b0001, 4'b0001, 1, "en_first");
        cyc(4'b0011, 1, 1, 4'b0001, 4'b0010, 1, "en_second");
        cyc(4'b0011, 0, 1, 4'b0000, 4'b0000, 1, "en_off0");
        cyc(4'b0011, 0, 1, 4'b0000, 4'b0000, 1, "en_off1");
        cyc(4'b0011, 1, 1, 4'b0010, 4'b0001, 1, "en_resume");

        do_reset();
        cyc(4'b0010, 1, 1, 4'b0010, 4'b0010, 1, "pre_rst");
        reset = 1'b1;
        #2;
        chk("async_rst_h4", gnt, gv, gi, 4'b0000);
        chk("async_rst_h1", gnt1, gv1, gi1, 4'b0000);
        reset = 1'b0;
        cyc(4'b1010, 1, 1, 4'b0010, 4'b0010, 1, "post_rst");
        cyc(4'b1010, 1, 1, 4'b0010, 4'b1000, 1, "post_rst2");

        repeat (3) @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries never checked, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Parametrised N-way arbiter with registered, one-hot grants, selectable fixed-priority or round-robin mode, and grant hold with a bounded tenure. It replaces the combinational ps2/ps4/ps8/ps16 priority-selector tree wherever a shared resource must stay owned across cycles. Example resources are a CDB port, a memory bus or a functional-unit issue slot. It keeps the `en`/`req`/`gnt`/`req_up` contract and adds state: owner, rotation pointer and hold counter.

## Interface

- `N`, 16: number of requesters; N ≥ 2, power of two not required.
- `MAX_HOLD`, 4: maximum consecutive cycles one owner keeps the grant while others wait; ≥ 1.
- `IDXW`, $clog2(N): width of `gnt_idx`; derived, not overridden.

Ports:

- `clock` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `en` input 1: arbitration enable; low forces release.
- `rr_mode` input 1: 1 = round-robin, 0 = fixed priority (highest index wins).
- `req` input N: request vector, one bit per requester.
- `gnt` output N: registered one-hot grant, or all zero.
- `gnt_valid` output 1: registered; equals |`gnt`.
- `gnt_idx` output IDXW: registered index of the set `gnt` bit; 0 when `gnt_valid`=0.
- `req_up` output 1: combinational OR of `req`, independent of `en` and state.

## Operation

- State: `owner` (IDXW), `busy` (1 = IDLE/GRANT), `ptr` (IDXW, last winner), `hold_cnt` ($clog2(MAX_HOLD+1) bits).
- Reset values:
  - `gnt`=0, `gnt_valid`=0, `gnt_idx`=0.
  - `busy`=0 (IDLE), `owner`=0.
  - `ptr`=N-1, so the first round-robin search starts at index 0.
  - `hold_cnt`=0.
- Winner select over candidate vector `cand`:
  - Fixed mode: highest set index.
  - RR mode: first set bit scanning ascending from (`ptr`+1) mod N, wrapping through N-1 to 0.
- Per rising edge, evaluated in order:
  1. `en`=0: go IDLE; `gnt`=0; `hold_cnt`=0; `ptr` unchanged.
  2. GRANT, `req[owner]`=1, and either `hold_cnt` < MAX_HOLD-1 or no other `req` bit set: keep `owner`.
     - `hold_cnt` increments.
     - It wraps to 0 when it would reach MAX_HOLD with no other requester.
  3. GRANT, `req[owner]`=1, `hold_cnt` = MAX_HOLD-1, and others pending: tenure expired.
     - `cand` = `req` with `owner` bit cleared.
  4. Otherwise `cand` = `req`. This covers IDLE, and an owner that dropped `req`.
  - For cases 3/4:
    - `cand`=0: go IDLE, `gnt`=0.
    - `cand`≠0: go GRANT with `owner`=winner, `ptr`=winner, `hold_cnt`=0, and `gnt`/`gnt_idx` updated.
- Release: an owner drops `req` to release. The next owner is chosen on that same edge, so there are no dead cycles between owners.
- `rr_mode` is sampled only at arbitration decisions (cases 3/4). A change mid-tenure does not preempt the current owner.
- `ptr` updates in both modes. Switching to RR continues rotation from the last winner.
- MAX_HOLD=1: every edge with other requesters pending re-arbitrates. In RR mode this is a strict rotation.
- Fixed mode with tenure expiry: the highest pending index other than the owner wins. Low indices can still starve; this is intentional.

## Timing

- Latency: `req` sampled at edge k; `gnt` visible after edge k (one cycle). There is no combinational path from `req` to `gnt`.
- `req_up` is combinational, with zero latency.
- Hold: a continuously requesting owner, with others pending, holds `gnt` for exactly MAX_HOLD cycles, then loses it.
- Reset asserted mid-tenure clears all outputs immediately, asynchronously. The first grant after deassertion appears one edge after `req` is seen.
- Simultaneous owner release and `en` fall: `en` wins; go IDLE.
- `gnt_idx` and `gnt` always change on the same edge; they are never inconsistent.

## Test plan

- N=4, MAX_HOLD=4, `rr_mode`=0; `req`=4'b0101 steady.
  - Required: `gnt`=4'b0100 from the first edge, `gnt_idx`=2.
  - After 4 cycles `gnt`=4'b0001 for 4 cycles, then back to 4'b0100.
- RR, MAX_HOLD=1, from reset, `req`=4'b1111 steady.
  - Required: `gnt_idx` sequence 0,1,2,3,0,… with one change per cycle and `gnt_valid` continuously 1.
- RR, MAX_HOLD=4, only `req[2]` high for 10 cycles.
  - Required: `gnt`=4'b0100 for all 10 cycles, no drop at hold wrap.
  - `req[2]` low → `gnt`=0 next edge.
- Owner 1 granted; at edge k `req[1]` falls while `req[3]` is high.
  - Required: after edge k, `gnt`=4'b1000 with no idle cycle.
- `en` low for 2 cycles during GRANT with `req`=4'b0011.
  - Required: `gnt`=0 for those cycles.
  - On re-enable in RR the search resumes from the stored `ptr`.
- `reset` pulsed between edges while `gnt`=4'b0010.
  - Required: `gnt`, `gnt_valid` and `gnt_idx` go to 0 before the next edge.
  - After release, the first RR winner for `req`=4'b1010 is index 1.
